// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the program-loader state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int pDATA_WIDTH = 8;
  localparam int pADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT,
    LD_ADDR,
    LD_DATA,
    LD_CHECK,
    LD_DONE
  } mem_loader_state_e;

endpackage

// File: rtl/common_reg.sv
// Enabled data register with asynchronous active-low clear.
// Latency: 1 cycle from ien to odata.
// Backpressure: none; holds its value while ien is low.
module common_reg #(
  parameter int pWIDTH = 8
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              ien,
  input  logic [pWIDTH-1:0] idata,
  output logic [pWIDTH-1:0] odata
);

  logic [pWIDTH-1:0] r_q;

  // Capture idata whenever enabled, otherwise hold
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_q <= '0;
    else if (ien) r_q <= idata;
  end

  assign odata = r_q;

endmodule

// File: rtl/mem_loader.sv
// Program loader: writes an upstream byte stream to memory words 0..pLOAD_WORDS-1 over the shared bus.
// Latency: 3 cycles per word (WAIT/ADDR/DATA); odone one cycle after the last DATA (or after CHECK).
// Backpressure: oready only in WAIT (and CHECK); optional checksum byte enabled by MEM_LOADER_CHKSUM_EN.
module mem_loader
  import cpu_pkg::*;
#(
  parameter int pDATA_WIDTH = cpu_pkg::pDATA_WIDTH,
  parameter int pADDR_WIDTH = cpu_pkg::pADDR_WIDTH,
  parameter int pLOAD_WORDS = 2**pADDR_WIDTH
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   istart,
  input  logic                   ivalid,
  input  logic [pDATA_WIDTH-1:0] idata,
  output logic                   oready,
  output logic [pDATA_WIDTH-1:0] obus,
  output logic                   obus_oe,
  output logic                   oaen,
  output logic                   oden,
  output logic                   ocpu_hold,
  output logic                   odone,
  output logic                   oerr
);

  localparam logic [pADDR_WIDTH-1:0] LAST_IDX = pADDR_WIDTH'(pLOAD_WORDS - 1);

  mem_loader_state_e             r_state;
  mem_loader_state_e             w_next;
  logic [pADDR_WIDTH-1:0]        r_cnt;
  logic                          r_hold;
  logic [pDATA_WIDTH-1:0]        w_byte;
  logic [pDATA_WIDTH-1:0]        w_addr_ext;
  logic                          w_hs;
  logic                          w_last;
  logic                          w_start;

  assign w_hs    = ivalid & oready;
  assign w_last  = (r_cnt == LAST_IDX);
  assign w_start = (r_state == LD_IDLE) & istart;

  // Byte register: captures every accepted upstream byte
  common_reg #(
    .pWIDTH (pDATA_WIDTH)
  ) u_byte (
    .iclk   (iclk),
    .irst_n (irst_n),
    .ien    (w_hs),
    .idata  (idata),
    .odata  (w_byte)
  );

  // Word counter zero-extended onto the bus during the address phase
  always_comb begin
    w_addr_ext                  = '0;
    w_addr_ext[pADDR_WIDTH-1:0] = r_cnt;
  end

  // State register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= LD_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and bus/handshake outputs; everything idles at 0
  always_comb begin
    w_next  = r_state;
    oready  = 1'b0;
    obus    = '0;
    obus_oe = 1'b0;
    oaen    = 1'b0;
    oden    = 1'b0;
    odone   = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (istart) w_next = LD_WAIT;
      end
      LD_WAIT: begin
        oready = 1'b1;
        if (ivalid) w_next = LD_ADDR;
      end
      LD_ADDR: begin
        obus    = w_addr_ext;
        obus_oe = 1'b1;
        oaen    = 1'b1;
        w_next  = LD_DATA;
      end
      LD_DATA: begin
        obus    = w_byte;
        obus_oe = 1'b1;
        oden    = 1'b1;
        if (w_last) begin
`ifdef MEM_LOADER_CHKSUM_EN
          w_next = LD_CHECK;
`else
          w_next = LD_DONE;
`endif
        end else begin
          w_next = LD_WAIT;
        end
      end
`ifdef MEM_LOADER_CHKSUM_EN
      LD_CHECK: begin
        oready = 1'b1;
        if (ivalid) w_next = LD_DONE;
      end
`endif
      LD_DONE: begin
        odone  = 1'b1;
        w_next = LD_IDLE;
      end
      default: w_next = LD_IDLE;
    endcase
  end

  // Word counter: cleared on start, advanced after each non-final word
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)                              r_cnt <= '0;
    else if (w_start)                         r_cnt <= '0;
    else if (r_state == LD_DATA && !w_last)   r_cnt <= r_cnt + 1'b1;
  end

  // CPU hold: raised on start, released as DONE is left
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)                  r_hold <= 1'b0;
    else if (w_start)             r_hold <= 1'b1;
    else if (r_state == LD_DONE)  r_hold <= 1'b0;
  end

  assign ocpu_hold = r_hold;

`ifdef MEM_LOADER_CHKSUM_EN
  logic [pDATA_WIDTH-1:0] r_sum;
  logic [pDATA_WIDTH-1:0] w_sum_fin;
  logic                   r_err;

  assign w_sum_fin = r_sum + idata;

  // Running modular sum of image bytes accepted in WAIT
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)                          r_sum <= '0;
    else if (w_start)                     r_sum <= '0;
    else if (r_state == LD_WAIT && ivalid) r_sum <= w_sum_fin;
  end

  // Sticky checksum error, judged on the trailing byte and cleared by the next start
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)                            r_err <= 1'b0;
    else if (w_start)                       r_err <= 1'b0;
    else if (r_state == LD_CHECK && ivalid) r_err <= (w_sum_fin != '0);
  end

  assign oerr = r_err;
`else
  assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: 4-word and 16-word instances behind a shared stimulus mux.
// Latency: expects odone 3 cycles per word after the first handshake (+1 with MEM_LOADER_CHKSUM_EN).
// Backpressure: upstream stalls and busy istart are exercised; a bus-level memory model records writes.
module tb_mem_loader;

`ifdef MEM_LOADER_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       tb_start;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic       sel;

  always #5 iclk = ~iclk;

  logic       a_ready, a_oe, a_aen, a_den, a_hold, a_done, a_err;
  logic [7:0] a_bus;
  logic       b_ready, b_oe, b_aen, b_den, b_hold, b_done, b_err;
  logic [7:0] b_bus;

  mem_loader #(.pDATA_WIDTH(8), .pADDR_WIDTH(4), .pLOAD_WORDS(4)) u_dut4 (
    .iclk(iclk), .irst_n(irst_n), .istart(tb_start & ~sel), .ivalid(tb_valid & ~sel),
    .idata(tb_data), .oready(a_ready), .obus(a_bus), .obus_oe(a_oe), .oaen(a_aen),
    .oden(a_den), .ocpu_hold(a_hold), .odone(a_done), .oerr(a_err)
  );

  mem_loader #(.pDATA_WIDTH(8), .pADDR_WIDTH(4), .pLOAD_WORDS(16)) u_dut16 (
    .iclk(iclk), .irst_n(irst_n), .istart(tb_start & sel), .ivalid(tb_valid & sel),
    .idata(tb_data), .oready(b_ready), .obus(b_bus), .obus_oe(b_oe), .oaen(b_aen),
    .oden(b_den), .ocpu_hold(b_hold), .odone(b_done), .oerr(b_err)
  );

  wire       w_ready = sel ? b_ready : a_ready;
  wire [7:0] w_bus   = sel ? b_bus   : a_bus;
  wire       w_oe    = sel ? b_oe    : a_oe;
  wire       w_aen   = sel ? b_aen   : a_aen;
  wire       w_den   = sel ? b_den   : a_den;
  wire       w_hold  = sel ? b_hold  : a_hold;
  wire       w_done  = sel ? b_done  : a_done;
  wire       w_err   = sel ? b_err   : a_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int hs_cyc;
  int n_done;
  int n_writes;

  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];
  logic [7:0] mem [16];
  logic [3:0] maddr;
  logic [7:0] img [16];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge iclk) cyc++;

  // Bus monitor and memory model: address latched on oaen, data written on oden
  always @(negedge iclk) begin
    if (irst_n) begin
      chk_eq("aen_den_excl", {31'd0, w_aen & w_den}, 0);
      chk_eq("oe_low_bus_zero", {31'd0, (!w_oe && w_bus != 8'd0)}, 0);
      if (w_aen) begin
        if (q_addr.size() == 0) chk_eq("spurious_aen", 1, 0);
        else chk_eq("aen_addr", {24'd0, w_bus}, {24'd0, q_addr.pop_front()});
        maddr = w_bus[3:0];
      end
      if (w_den) begin
        if (q_data.size() == 0) chk_eq("spurious_den", 1, 0);
        else chk_eq("den_data", {24'd0, w_bus}, {24'd0, q_data.pop_front()});
        mem[maddr] = w_bus;
        n_writes++;
      end
      if (w_done) n_done++;
    end
  end

  // Present one byte at a negedge and return at the negedge after it is accepted
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    tb_valid = 1'b1;
    tb_data  = b;
    while (!w_ready && t < 60) begin
      @(negedge iclk);
      t++;
    end
    chk_eq("hs_timeout", {31'd0, t >= 60}, 0);
    if (hs_cyc < 0) hs_cyc = cyc;
    @(negedge iclk);
    tb_valid = 1'b0;
  endtask

  task automatic run_load(input logic s, input int n, input int gap,
                          input logic busy_start, input logic bad);
    logic [7:0] sum;
    int t;
    sel = s;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    n_writes = 0;
    n_done   = 0;
    hs_cyc   = -1;
    sum      = 8'h00;
    for (int i = 0; i < n; i++) begin
      q_addr.push_back(8'(i));
      q_data.push_back(img[i]);
      sum = sum + img[i];
    end
    @(negedge iclk);
    tb_start = 1'b1;
    @(negedge iclk);
    tb_start = busy_start;
    chk_eq("hold_set", {31'd0, w_hold}, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i]);
      if (gap > 0 && i < n - 1) begin
        for (int j = 1; j <= gap; j++) begin
          @(negedge iclk);
          if (j >= 2) chk_eq("ready_held", {31'd0, w_ready}, 1);
        end
      end
    end
    if (CHK == 1) send_byte(8'(0) - sum + 8'(bad));
    t = 0;
    while (!w_done && t < 200) begin
      @(negedge iclk);
      t++;
    end
    chk_eq("done_timeout", {31'd0, t >= 200}, 0);
    tb_start = 1'b0;
    chk_eq("hold_at_done", {31'd0, w_hold}, 1);
    if (gap == 0) chk_eq("done_latency", cyc - hs_cyc, 3 * n + CHK);
    @(negedge iclk);
    chk_eq("hold_dropped", {31'd0, w_hold}, 0);
    chk_eq("err_flag", {31'd0, w_err}, (CHK == 1) ? {31'd0, bad} : 0);
    repeat (4) @(negedge iclk);
    chk_eq("done_count", n_done, 1);
    chk_eq("addr_left", q_addr.size(), 0);
    chk_eq("data_left", q_data.size(), 0);
    chk_eq("write_count", n_writes, n);
    for (int i = 0; i < n; i++) chk_eq($sformatf("mem[%0d]", i), {24'd0, mem[i]}, {24'd0, img[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    irst_n   = 1'b0;
    tb_start = 1'b0;
    tb_valid = 1'b0;
    tb_data  = 8'h00;
    sel      = 1'b0;
    maddr    = 4'h0;
    n_done   = 0;
    n_writes = 0;
    hs_cyc   = -1;
    #12;
    chk_eq("rst_outs_4",  {17'd0, a_ready, a_oe, a_aen, a_den, a_hold, a_done, a_err, a_bus}, 0);
    chk_eq("rst_outs_16", {17'd0, b_ready, b_oe, b_aen, b_den, b_hold, b_done, b_err, b_bus}, 0);
    @(negedge iclk);
    irst_n = 1'b1;

    // Back-to-back 4-word image
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    run_load(1'b0, 4, 0, 1'b0, 1'b0);

    // Upstream stalls between bytes
    run_load(1'b0, 4, 5, 1'b0, 1'b0);

    // istart held high throughout the load
    run_load(1'b0, 4, 0, 1'b1, 1'b0);

    // Reset during the first DATA cycle
    q_addr.push_back(8'h00);
    q_data.push_back(8'h11);
    @(negedge iclk);
    tb_start = 1'b1;
    @(negedge iclk);
    tb_start = 1'b0;
    send_byte(8'h11);
    @(negedge iclk);
    chk_eq("pre_rst_den", {31'd0, a_den}, 1);
    #2;
    irst_n = 1'b0;
    #1;
    chk_eq("mid_rst_outs", {17'd0, a_ready, a_oe, a_aen, a_den, a_hold, a_done, a_err, a_bus}, 0);
    q_addr.delete();
    q_data.delete();
    @(negedge iclk);
    irst_n = 1'b1;
    img[0] = 8'h5A; img[1] = 8'hC3; img[2] = 8'h07; img[3] = 8'hE8;
    run_load(1'b0, 4, 0, 1'b0, 1'b0);

`ifdef MEM_LOADER_CHKSUM_EN
    // Checksum: good trailer 0xF6, then bad trailer 0xF7
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    run_load(1'b0, 4, 0, 1'b0, 1'b0);
    run_load(1'b0, 4, 0, 1'b0, 1'b1);
`endif

    // Full 16-word image on the second instance
    for (int i = 0; i < 16; i++) img[i] = 8'hA0 + 8'(i);
    run_load(1'b1, 16, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
